// File: rtl/bist_pkg.sv
// Shared definitions for the exhaustive-sweep BIST engine: FSM encoding and MISR constants.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        APPLY     = 2'd1,
        WAIT_STEP = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/bist_sweep_misr16.sv
// 16-bit single-input signature register (CRC-CCITT polynomial) compacting the sweep responses.
module misr16
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] sig
);

    logic fb;
    assign fb = sig[15] ^ din;

    always_ff @(posedge clk) begin
        if (rst)
            sig <= 16'h0000;
        else if (load)
            sig <= MISR_SEED;
        else if (shift)
            sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end

endmodule

// File: rtl/bist_sweep.sv
// Exhaustive stimulus sweep with response counting; optional MISR signature when
// BIST_SWEEP_MISR_EN is defined (otherwise signature reads as zero).
module bist_sweep
    import bist_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             resp_in,
    output logic [WIDTH-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   ones_count,
    output logic [15:0]      signature
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [WIDTH-1:0] VEC_MAX   = {WIDTH{1'b1}};

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          start_ok;
    logic          sample_now;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign sample_now = (state == APPLY) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
            hold_cnt   <= '0;
        end else if (start_ok) begin
            state      <= APPLY;
            vec_out    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            ones_count <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                APPLY: begin
                    if (sample_now) begin
                        hold_cnt <= '0;
                        if (resp_in)
                            ones_count <= ones_count + 1'b1;
                        // Last vector: stop without wrapping so the final value stays visible.
                        if (vec_out == VEC_MAX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (step_mode) begin
                            state <= WAIT_STEP;
                        end else begin
                            vec_out <= vec_out + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_STEP: begin
                    // Dropping step_mode while parked resumes free-run from this boundary.
                    if (step || !step_mode) begin
                        state   <= APPLY;
                        vec_out <= vec_out + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIST_SWEEP_MISR_EN
    misr16 u_misr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_ok),
        .shift (sample_now),
        .din   (resp_in),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_bist_sweep.sv
// Directed self-checking bench: 5-bit/hold-2 free-run instance and 3-bit/hold-1 step-mode instance.
module tb_bist_sweep;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=5, HOLD=2
    logic       start_a = 1'b0, step_mode_a = 1'b0, step_a = 1'b0, resp_a;
    logic [4:0] vec_a;
    logic       busy_a, done_a;
    logic [5:0] ones_a;
    logic [15:0] sig_a;
    int         resp_sel = 0;
    logic       flip_en = 1'b0;

    always_comb begin
        resp_a = 1'b0;
        case (resp_sel)
            0: resp_a = vec_a[0];
            1: resp_a = &vec_a;
            2: resp_a = vec_a[4] ^ vec_a[0];
            default: resp_a = 1'b1;
        endcase
        if (flip_en && vec_a == 5'd7)
            resp_a = ~resp_a;
    end

    bist_sweep #(.WIDTH(5), .HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .step_mode(step_mode_a), .step(step_a),
        .resp_in(resp_a), .vec_out(vec_a), .busy(busy_a), .done(done_a),
        .ones_count(ones_a), .signature(sig_a)
    );

    // Instance B: WIDTH=3, HOLD=1, every response 1
    logic       start_b = 1'b0, step_mode_b = 1'b0, step_b = 1'b0;
    logic [2:0] vec_b;
    logic       busy_b, done_b;
    logic [3:0] ones_b;
    logic [15:0] sig_b;

    bist_sweep #(.WIDTH(3), .HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .step_mode(step_mode_b), .step(step_b),
        .resp_in(1'b1), .vec_out(vec_b), .busy(busy_b), .done(done_b),
        .ones_count(ones_b), .signature(sig_b)
    );

    function automatic logic [15:0] misr_model(input logic flip);
        logic [15:0] s;
        logic [4:0]  v;
        logic        r, fb;
        s = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            v  = 5'(i);
            r  = v[4] ^ v[0] ^ (flip && i == 7);
            fb = s[15] ^ r;
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_a) begin
            errors++;
            $display("FAIL %s timeout: done=%0b after %0d cycles, required 1", name, done_a, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec_a, busy_a, done_a, ones_a, sig_a} !== 29'd0) begin
            errors++;
            $display("FAIL reset_a: vec=%0d busy=%0b done=%0b ones=%0d sig=%h, required all 0",
                     vec_a, busy_a, done_a, ones_a, sig_a);
        end
        checks++;
        if ({vec_b, busy_b, done_b, ones_b, sig_b} !== 25'd0) begin
            errors++;
            $display("FAIL reset_b: vec=%0d busy=%0b done=%0b ones=%0d sig=%h, required all 0",
                     vec_b, busy_b, done_b, ones_b, sig_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_baseline();
        int cyc = 0;
        int bad = 0;
        resp_sel = 0;
        pulse_start_a();
        while (busy_a && cyc < 200) begin
            if (vec_a !== 5'(cyc / 2)) bad++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL baseline_seq: %0d cycles with vec_out != cycle/2, required 0", bad);
        end
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL baseline_busy_len: got %0d, required 64", cyc);
        end
        checks++;
        if (done_a !== 1'b1 || ones_a !== 6'd16 || vec_a !== 5'd31) begin
            errors++;
            $display("FAIL baseline_result: done=%0b ones=%0d vec=%0d, required 1/16/31",
                     done_a, ones_a, vec_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || ones_a !== 6'd16 || vec_a !== 5'd31) begin
            errors++;
            $display("FAIL done_hold: done=%0b ones=%0d vec=%0d, required 1/16/31",
                     done_a, ones_a, vec_a);
        end
    endtask

    task automatic test_minterm();
        resp_sel = 1;
        pulse_start_a();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || ones_a !== 6'd0 || vec_a !== 5'd0) begin
            errors++;
            $display("FAIL restart_from_done: done=%0b busy=%0b ones=%0d vec=%0d, required 0/1/0/0",
                     done_a, busy_a, ones_a, vec_a);
        end
        wait_done_a("minterm");
        checks++;
        if (ones_a !== 6'd1 || vec_a !== 5'd31) begin
            errors++;
            $display("FAIL minterm: ones=%0d vec=%0d, required 1/31", ones_a, vec_a);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc = 0;
        resp_sel = 3;
        pulse_start_a();
        while (busy_a && cyc < 200) begin
            start_a = (cyc == 10);
            cyc++;
            @(negedge clk);
        end
        start_a = 1'b0;
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL busy_start_len: got %0d, required 64", cyc);
        end
        checks++;
        if (ones_a !== 6'd32 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL all_ones: ones=%0d done=%0b, required 32/1", ones_a, done_a);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        resp_sel = 3;
        pulse_start_a();
        while (vec_a !== 5'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (vec_a !== 5'd10) begin
            errors++;
            $display("FAIL reach_vec10: vec=%0d, required 10", vec_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({vec_a, busy_a, done_a, ones_a, sig_a} !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid: vec=%0d busy=%0b done=%0b ones=%0d sig=%h, required all 0",
                     vec_a, busy_a, done_a, ones_a, sig_a);
        end
        pulse_start_a();
        checks++;
        if (vec_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_rst: vec=%0d busy=%0b, required 0/1", vec_a, busy_a);
        end
        repeat (5) @(negedge clk);
        // rst and start together: reset wins
        rst = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || vec_a !== 5'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: busy=%0b vec=%0d done=%0b, required 0/0/0",
                     busy_a, vec_a, done_a);
        end
    endtask

    task automatic test_step_mode();
        int n = 0;
        step_mode_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) begin
            start_b = 1'b0;
            step_b  = 1'b1;   // arrives while in APPLY
        end
        @(negedge clk) step_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (vec_b !== 3'd0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL step_in_apply: vec=%0d busy=%0b, required 0/1", vec_b, busy_b);
        end
        for (int i = 0; i < 3; i++) begin
            step_b = 1'b1;
            @(negedge clk) step_b = 1'b0;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (vec_b !== 3'd3 || busy_b !== 1'b1 || done_b !== 1'b0 || ones_b !== 4'd4) begin
            errors++;
            $display("FAIL step_wait: vec=%0d busy=%0b done=%0b ones=%0d, required 3/1/0/4",
                     vec_b, busy_b, done_b, ones_b);
        end
        step_mode_b = 1'b0;
        while (!done_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_b !== 1'b1 || vec_b !== 3'd7 || ones_b !== 4'd8 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL step_to_free: done=%0b vec=%0d ones=%0d busy=%0b, required 1/7/8/0",
                     done_b, vec_b, ones_b, busy_b);
        end
    endtask

    task automatic test_misr();
        logic [15:0] sig_clean;
        logic [15:0] exp_clean, exp_flip;
        exp_clean = misr_model(1'b0);
        exp_flip  = misr_model(1'b1);
        resp_sel = 2;
        flip_en  = 1'b0;
        pulse_start_a();
        wait_done_a("misr_clean");
        sig_clean = sig_a;
`ifdef BIST_SWEEP_MISR_EN
        checks++;
        if (sig_a !== exp_clean) begin
            errors++;
            $display("FAIL misr_clean: sig=%h, required %h", sig_a, exp_clean);
        end
`else
        checks++;
        if (sig_a !== 16'h0000) begin
            errors++;
            $display("FAIL sig_tied: sig=%h, required 0000", sig_a);
        end
`endif
        flip_en = 1'b1;
        pulse_start_a();
        wait_done_a("misr_flip");
        flip_en = 1'b0;
`ifdef BIST_SWEEP_MISR_EN
        checks++;
        if (sig_a !== exp_flip) begin
            errors++;
            $display("FAIL misr_flip: sig=%h, required %h", sig_a, exp_flip);
        end
        checks++;
        if (sig_a === sig_clean) begin
            errors++;
            $display("FAIL misr_sensitivity: flipped sig=%h equals clean sig=%h", sig_a, sig_clean);
        end
`else
        checks++;
        if (sig_a !== 16'h0000 || exp_flip === exp_clean) begin
            errors++;
            $display("FAIL sig_tied_flip: sig=%h, required 0000", sig_a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_minterm();
        test_start_while_busy();
        test_reset_mid();
        test_step_mode();
        test_misr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_sweep.md
BIST_SWEEP -- requirements
Module: bist_sweep

Interface
REQ-001 Parameter WIDTH, default 5: number of stimulus bits driven to the DUT under test (2 to 16).
REQ-002 Parameter HOLD, default 2: cycles each vector is held; must be at least 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a sweep; honoured only in IDLE or DONE.
REQ-006 step_mode  input  1  0 = free-run; 1 = advance one vector per step pulse.
REQ-007 step  input  1  single-cycle advance request; used only when step_mode=1.
REQ-008 resp_in  input  1  DUT response to the current vec_out.
REQ-009 vec_out  output  WIDTH  stimulus vector, registered.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  level; high from sweep completion until the next start or reset.
REQ-012 ones_count  output  WIDTH+1  number of sampled resp_in=1 during the sweep.
REQ-013 signature  output  16  response signature (see Configuration).

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, APPLY, WAIT_STEP and DONE.
REQ-015 Start handling: start=1 in IDLE or DONE SHALL, at the next edge, do all of the following:
- enter APPLY;
- set busy=1, done=0 and vec_out=0;
- clear ones_count;
- seed signature.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 APPLY timing:
- each vector SHALL be held exactly HOLD cycles;
- resp_in SHALL be sampled on the last hold cycle only;
- a sample with resp_in=1 SHALL increment ones_count.
REQ-018 Free-run: after a sample, vec_out SHALL increment by 1 on the next edge.
REQ-019 Step mode: after a sample, the FSM SHALL enter WAIT_STEP, holding vec_out. A step pulse SHALL then increment vec_out and return to APPLY. A step pulse arriving during APPLY SHALL be ignored.
REQ-020 End of sweep: after vec_out = 2^WIDTH-1 is sampled, the FSM SHALL enter DONE with busy=0 and done=1; vec_out SHALL NOT wrap to 0.
REQ-021 Free-run latency: busy SHALL stay high for exactly 2^WIDTH*HOLD cycles.
REQ-022 Completion value: ones_count SHALL equal 2^WIDTH when every sample is 1; its width SHALL prevent overflow.
REQ-023 step_mode SHALL be sampled continuously. A change mid-sweep takes effect at the next vector boundary.
REQ-024 In DONE, vec_out, ones_count and signature SHALL hold their values until the next start.

Reset
REQ-025 rst=1 SHALL, at the next edge, force IDLE with vec_out=0, busy=0, done=0, ones_count=0 and signature=16'h0000, regardless of state.
REQ-026 Reset mid-sweep SHALL abandon the sweep; no done pulse and no partial result SHALL be retained.
REQ-027 rst SHALL take priority over start and step in the same cycle.

Configuration
REQ-028 The feature is controlled by the macro BIST_SWEEP_MISR_EN.
REQ-029 With BIST_SWEEP_MISR_EN defined:
- signature is a 16-bit MISR with polynomial 16'h1021, seeded to 16'hFFFF at start;
- per sample: fb = signature[15]^resp_in; signature <= {signature[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
REQ-030 With BIST_SWEEP_MISR_EN undefined: signature SHALL be tied to 16'h0000, and no MISR logic SHALL be synthesised.

Structure
REQ-031 A shared package bist_pkg SHALL hold the state encoding (IDLE=0, APPLY=1, WAIT_STEP=2, DONE=3), MISR_POLY=16'h1021 and MISR_SEED=16'hFFFF.
REQ-032 The MISR SHALL be a separate sub-module, misr16, with ports clk, rst, load, shift, din and sig; it is instantiated only under BIST_SWEEP_MISR_EN.

Verification
REQ-033 Baseline sweep, WIDTH=5, HOLD=2, free-run, resp_in=vec_out[0]:
- stimulus: start pulse;
- required: busy high for 64 cycles, vec_out 0..31 each held 2 cycles, then done=1 and ones_count=16.
REQ-034 Single-minterm response, resp_in = &vec_out, WIDTH=5 -> ones_count=1 and final vec_out=31.
REQ-035 Step mode, WIDTH=3, HOLD=1:
- stimulus: start, then 3 step pulses;
- required: vec_out=3 held in WAIT_STEP, busy=1, done=0; step pulses during APPLY have no effect.
REQ-036 Reset mid-sweep at vec_out=10:
- stimulus: rst asserted;
- required: next cycle all outputs 0 and state IDLE; a subsequent start restarts from vec_out=0.
REQ-037 start asserted while busy=1 -> ignored; sweep length unchanged.
REQ-038 With BIST_SWEEP_MISR_EN, resp_in=vec_out[4]^vec_out[0]:
- required: signature matches the bench's software MISR model after 32 samples;
- flipping one response bit SHALL change signature.
